hdlc_rx_frame_fifo: RTL and testbench

//  Packet-mode byte FIFO between the RS422/HDLC receive stream (push-only AXIS, no tready) and the
//  AXI-Stream DMA (S2MM) port. Buffers each frame whole and releases it only after its tlast byte.

---
 rtl/hdlc_rx_frame_fifo_pkg.sv | 13 +
 rtl/rx_frame_ram.sv | 34 +++
 rtl/hdlc_rx_frame_fifo.sv | 130 +++++++++++++
 tb/tb_hdlc_rx_frame_fifo.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdlc_rx_frame_fifo_pkg.sv
// Shared definitions for the HDLC receive frame FIFO: FSM encodings, default sizes, entry layout.
package hdlc_rx_frame_fifo_pkg;

  localparam int DEF_ADDR_W = 11;
  localparam int DEF_CNT_W  = 16;

  localparam logic [0:0] ST_ACCEPT = 1'b0;
  localparam logic [0:0] ST_DROP   = 1'b1;

  // RAM entry: {tlast, tdata}
  typedef logic [8:0] entry_t;

endpackage

// File: rtl/rx_frame_ram.sv
// Simple dual-port 9-bit frame buffer: one write port, one read port with an enabled output register.
module rx_frame_ram
  import hdlc_rx_frame_fifo_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  entry_t            wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output entry_t            rdata
);

  entry_t mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read register doubles as the FIFO output register, so it holds while re is low.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/hdlc_rx_frame_fifo.sv
// Packet-mode byte FIFO: buffers whole HDLC frames, releases them after tlast, drops overflowing frames.
module hdlc_rx_frame_fifo
  import hdlc_rx_frame_fifo_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              s_tvalid,
  input  logic              s_tlast,
  input  logic [7:0]        s_tdata,
  input  logic              abort,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              m_tlast,
  output logic [7:0]        m_tdata,
  output logic [ADDR_W:0]   level,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic              drop_pulse
);

  localparam int PW = ADDR_W + 1;
  localparam logic [PW-1:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  logic [0:0]    state, state_d;
  logic [PW-1:0] wr_ptr, wr_ptr_d;
  logic [PW-1:0] cm_ptr, cm_ptr_d;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] ft_ptr;
  logic [PW-1:0] used;
  logic          full;
  logic          we;
  logic          drop;
  logic          commit;
  logic          load;
  logic          pop;
  entry_t        rdata;

  // rd_ptr marks the oldest unconsumed byte, so the output register still occupies its slot.
  assign used   = wr_ptr - rd_ptr;
  assign full   = (used == DEPTH);
  assign ft_ptr = rd_ptr + {{ADDR_W{1'b0}}, m_tvalid};
  assign pop    = m_tvalid && m_tready;
  assign load   = (!m_tvalid || m_tready) && (ft_ptr != cm_ptr);
  assign level  = cm_ptr - rd_ptr;

  always_comb begin
    state_d  = state;
    wr_ptr_d = wr_ptr;
    cm_ptr_d = cm_ptr;
    we       = 1'b0;
    drop     = 1'b0;
    commit   = 1'b0;
    if (abort) begin
      wr_ptr_d = cm_ptr;
      state_d  = ST_ACCEPT;
      drop     = (wr_ptr != cm_ptr) || (state == ST_DROP);
    end else if (s_tvalid) begin
      if (state == ST_ACCEPT) begin
        if (!full) begin
          we       = 1'b1;
          wr_ptr_d = wr_ptr + PW'(1);
          if (s_tlast) begin
            cm_ptr_d = wr_ptr + PW'(1);
            commit   = 1'b1;
          end
        end else begin
          wr_ptr_d = cm_ptr;
          drop     = 1'b1;
          if (!s_tlast) begin
            state_d = ST_DROP;
          end
        end
      end else if (s_tlast) begin
        state_d = ST_ACCEPT;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_ACCEPT;
      wr_ptr     <= '0;
      cm_ptr     <= '0;
      rd_ptr     <= '0;
      m_tvalid   <= 1'b0;
      frame_cnt  <= '0;
      drop_cnt   <= '0;
      drop_pulse <= 1'b0;
    end else begin
      state      <= state_d;
      wr_ptr     <= wr_ptr_d;
      cm_ptr     <= cm_ptr_d;
      drop_pulse <= drop;
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (load) begin
        m_tvalid <= 1'b1;
      end else if (pop) begin
        m_tvalid <= 1'b0;
      end
      if (commit) begin
        frame_cnt <= frame_cnt + CNT_W'(1);
      end
      if (drop && (drop_cnt != {CNT_W{1'b1}})) begin
        drop_cnt <= drop_cnt + CNT_W'(1);
      end
    end
  end

  rx_frame_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .rstn  (rstn),
    .we    (we),
    .waddr (wr_ptr[ADDR_W-1:0]),
    .wdata ({s_tlast, s_tdata}),
    .re    (load),
    .raddr (ft_ptr[ADDR_W-1:0]),
    .rdata (rdata)
  );

  assign m_tlast = rdata[8];
  assign m_tdata = rdata[7:0];

endmodule

// File: tb/tb_hdlc_rx_frame_fifo.sv
// Directed self-checking bench for hdlc_rx_frame_fifo with a 16-byte buffer.
module tb_hdlc_rx_frame_fifo;

  localparam int AW = 4;
  localparam int CW = 16;

  logic          clk;
  logic          rstn;
  logic          s_tvalid;
  logic          s_tlast;
  logic [7:0]    s_tdata;
  logic          abort;
  logic          m_tvalid;
  logic          m_tready;
  logic          m_tlast;
  logic [7:0]    m_tdata;
  logic [AW:0]   level;
  logic [CW-1:0] frame_cnt;
  logic [CW-1:0] drop_cnt;
  logic          drop_pulse;

  int checks = 0;
  int errors = 0;
  int pulse_seen = 0;
  int exp_frames = 0;
  int exp_drops = 0;
  logic [8:0] got_q[$];
  logic [8:0] exp_q[$];

  hdlc_rx_frame_fifo #(
    .ADDR_W (AW),
    .CNT_W  (CW)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .s_tvalid   (s_tvalid),
    .s_tlast    (s_tlast),
    .s_tdata    (s_tdata),
    .abort      (abort),
    .m_tvalid   (m_tvalid),
    .m_tready   (m_tready),
    .m_tlast    (m_tlast),
    .m_tdata    (m_tdata),
    .level      (level),
    .frame_cnt  (frame_cnt),
    .drop_cnt   (drop_cnt),
    .drop_pulse (drop_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change at posedge+1, so the negedge sees what the next posedge will act on.
  always @(negedge clk) begin
    if (rstn) begin
      if (m_tvalid && m_tready) got_q.push_back({m_tlast, m_tdata});
      if (drop_pulse) pulse_seen++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic idle();
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    abort    = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    s_tvalid = 1'b1;
    s_tlast  = l;
    s_tdata  = d;
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic wait_out(input int n);
    for (int i = 0; i < 200; i++) begin
      if (got_q.size() >= n) break;
      idle();
    end
  endtask

  task automatic cmp_stream(input string name);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s_count: got %0d bytes, want %0d", name, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL %s_byte%0d: got %h, want %h", name, i, got_q[i], exp_q[i]);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({m_tvalid, m_tlast, m_tdata, level, frame_cnt, drop_cnt, drop_pulse} !== 48'h0) begin
      errors++;
      $display("FAIL reset_outputs: got tvalid=%b tlast=%b data=%h level=%0d fc=%0d dc=%0d dp=%b, want all 0",
               m_tvalid, m_tlast, m_tdata, level, frame_cnt, drop_cnt, drop_pulse);
    end
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    m_tready = 1'b1;
    send(8'h7E, 1'b0);
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    send(8'h03, 1'b1);
    idle();
    idle();
    checks++;
    if (m_tvalid !== 1'b1) begin
      errors++;
      $display("FAIL basic_latency: m_tvalid got %b, want 1 by N+3", m_tvalid);
    end
    wait_out(4);
    exp_q = '{9'h07E, 9'h001, 9'h002, 9'h103};
    cmp_stream("basic");
    exp_frames = 1;
    checks++;
    if (frame_cnt !== CW'(exp_frames)) begin
      errors++;
      $display("FAIL basic_frame_cnt: got %0d, want %0d", frame_cnt, exp_frames);
    end
    checks++;
    if (level !== '0) begin
      errors++;
      $display("FAIL basic_level: got %0d, want 0", level);
    end
  endtask

  task automatic test_backpressure();
    m_tready = 1'b0;
    send(8'hA0, 1'b0);
    send(8'hA1, 1'b0);
    send(8'hA2, 1'b1);
    repeat (4) idle();
    checks++;
    if ({m_tvalid, m_tlast, m_tdata} !== {1'b1, 1'b0, 8'hA0}) begin
      errors++;
      $display("FAIL bp_head: got v=%b l=%b d=%h, want v=1 l=0 d=a0", m_tvalid, m_tlast, m_tdata);
    end
    checks++;
    if (level !== 5'd3) begin
      errors++;
      $display("FAIL bp_level: got %0d, want 3", level);
    end
    repeat (3) idle();
    checks++;
    if ({m_tvalid, m_tdata} !== {1'b1, 8'hA0}) begin
      errors++;
      $display("FAIL bp_stable: got v=%b d=%h, want v=1 d=a0", m_tvalid, m_tdata);
    end
    m_tready = 1'b1;
    wait_out(3);
    exp_q = '{9'h0A0, 9'h0A1, 9'h1A2};
    cmp_stream("bp");
    exp_frames = 2;
    checks++;
    if (frame_cnt !== CW'(exp_frames)) begin
      errors++;
      $display("FAIL bp_frame_cnt: got %0d, want %0d", frame_cnt, exp_frames);
    end
  endtask

  task automatic test_overflow();
    int p0;
    p0 = pulse_seen;
    m_tready = 1'b0;
    for (int i = 0; i < 12; i++) send(8'(8'h10 + i), i == 11);
    for (int i = 0; i < 8; i++) send(8'(8'h40 + i), i == 7);
    repeat (3) idle();
    exp_drops = 1;
    exp_frames = 3;
    checks++;
    if (drop_cnt !== CW'(exp_drops)) begin
      errors++;
      $display("FAIL ovf_drop_cnt: got %0d, want %0d", drop_cnt, exp_drops);
    end
    checks++;
    if (pulse_seen - p0 != 1) begin
      errors++;
      $display("FAIL ovf_pulses: got %0d, want 1", pulse_seen - p0);
    end
    checks++;
    if (level !== 5'd12) begin
      errors++;
      $display("FAIL ovf_level: got %0d, want 12", level);
    end
    checks++;
    if (frame_cnt !== CW'(exp_frames)) begin
      errors++;
      $display("FAIL ovf_frame_cnt: got %0d, want %0d", frame_cnt, exp_frames);
    end
    m_tready = 1'b1;
    wait_out(12);
    repeat (10) idle();
    for (int i = 0; i < 12; i++) exp_q.push_back({i == 11, 8'(8'h10 + i)});
    cmp_stream("ovf");
  endtask

  task automatic test_long_frame();
    m_tready = 1'b1;
    for (int i = 0; i < 20; i++) send(8'(8'h80 + i), i == 19);
    idle();
    exp_drops = 2;
    checks++;
    if (drop_cnt !== CW'(exp_drops)) begin
      errors++;
      $display("FAIL long_drop_cnt: got %0d, want %0d", drop_cnt, exp_drops);
    end
    checks++;
    if (got_q.size() != 0) begin
      errors++;
      $display("FAIL long_no_output: got %0d bytes, want 0", got_q.size());
    end
    send(8'hC0, 1'b0);
    send(8'hC1, 1'b0);
    send(8'hC2, 1'b1);
    wait_out(3);
    repeat (3) idle();
    exp_q = '{9'h0C0, 9'h0C1, 9'h1C2};
    cmp_stream("long_next");
    exp_frames = 4;
    checks++;
    if (frame_cnt !== CW'(exp_frames)) begin
      errors++;
      $display("FAIL long_frame_cnt: got %0d, want %0d", frame_cnt, exp_frames);
    end
  endtask

  task automatic test_abort();
    int p0;
    p0 = pulse_seen;
    m_tready = 1'b1;
    for (int i = 0; i < 5; i++) send(8'(8'hD0 + i), 1'b0);
    abort    = 1'b1;
    s_tvalid = 1'b1;
    s_tlast  = 1'b0;
    s_tdata  = 8'hEE;
    @(posedge clk);
    #1;
    repeat (5) idle();
    exp_drops = 3;
    checks++;
    if (drop_cnt !== CW'(exp_drops)) begin
      errors++;
      $display("FAIL abort_drop_cnt: got %0d, want %0d", drop_cnt, exp_drops);
    end
    checks++;
    if (pulse_seen - p0 != 1) begin
      errors++;
      $display("FAIL abort_pulses: got %0d, want 1", pulse_seen - p0);
    end
    checks++;
    if ({level, 9'(got_q.size())} !== {5'd0, 9'd0}) begin
      errors++;
      $display("FAIL abort_no_output: got level=%0d bytes=%0d, want 0/0", level, got_q.size());
    end
    send(8'hE0, 1'b0);
    send(8'hE1, 1'b1);
    wait_out(2);
    repeat (3) idle();
    exp_q = '{9'h0E0, 9'h1E1};
    cmp_stream("abort_next");
    exp_frames = 5;
    checks++;
    if (frame_cnt !== CW'(exp_frames)) begin
      errors++;
      $display("FAIL abort_frame_cnt: got %0d, want %0d", frame_cnt, exp_frames);
    end
  endtask

  task automatic test_reset_mid_drain();
    m_tready = 1'b0;
    for (int i = 0; i < 10; i++) send(8'(8'hF0 + i), i == 9);
    repeat (3) idle();
    m_tready = 1'b1;
    repeat (3) idle();
    exp_q = '{9'h0F0, 9'h0F1, 9'h0F2};
    cmp_stream("pre_reset");
    #2;
    rstn = 1'b0;
    #1;
    checks++;
    if ({m_tvalid, m_tlast, m_tdata, level, frame_cnt, drop_cnt, drop_pulse} !== 48'h0) begin
      errors++;
      $display("FAIL midreset_outputs: got tvalid=%b tlast=%b data=%h level=%0d fc=%0d dc=%0d dp=%b, want all 0",
               m_tvalid, m_tlast, m_tdata, level, frame_cnt, drop_cnt, drop_pulse);
    end
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    got_q.delete();
    send(8'h55, 1'b0);
    send(8'h66, 1'b0);
    send(8'h77, 1'b1);
    wait_out(3);
    repeat (3) idle();
    exp_q = '{9'h055, 9'h066, 9'h177};
    cmp_stream("post_reset");
    checks++;
    if ({frame_cnt, drop_cnt} !== {CW'(1), CW'(0)}) begin
      errors++;
      $display("FAIL post_reset_cnts: got fc=%0d dc=%0d, want 1/0", frame_cnt, drop_cnt);
    end
  endtask

  initial begin
    rstn     = 1'b0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tdata  = 8'h00;
    abort    = 1'b0;
    m_tready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_overflow();
    test_long_frame();
    test_abort();
    test_reset_mid_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
